// File: rtl/branch_resolution_unit.sv
// ---------------------------------------------------------------------------
// branch_resolution_unit
//
// Execute-side partner of the fetch-stage branch predictor. Every prediction
// made at fetch is recorded in an in-order in-flight queue. When the oldest
// instruction resolves in execute, the head entry is compared against the
// actual outcome. The unit then trains the predictor and, on a misprediction,
// redirects fetch and flushes the wrong-path entries.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   FETCH_VALID/PC/PRED_*    prediction made at fetch (pushed into the queue)
//   EX_VALID/IS_BRANCH/...   resolution of the oldest in-flight instruction
//   STALL                    queue full, fetch must hold
//   LEARN_*                  one-cycle training strobe to the predictor
//   REDIRECT_VALID/PC        one-cycle fetch restart on misprediction
//   FLUSHING                 high while the FSM is in FLUSH
//   UNDERFLOW                sticky: EX_VALID arrived with an empty queue
//   MISPREDICT_COUNT         saturating misprediction counter
//   DBG_STATE, DBG_COUNT     FSM state (0 = RUN, 1 = FLUSH) and queue occupancy
//
// Handshake: a fetch beat transfers on a rising edge where FETCH_VALID is
// high, the FSM is in RUN, no misprediction resolves that cycle, and either
// STALL is low or a pop happens in the same cycle. STALL acts as the inverted
// ready and depends only on registered state. A beat offered while STALL is
// high without a simultaneous pop is dropped, so fetch must hold while stalled.
// ---------------------------------------------------------------------------
module branch_resolution_unit #(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     FETCH_VALID,
    input  logic [31:0]              FETCH_PC,
    input  logic                     FETCH_PRED_TAKEN,
    input  logic [31:0]              FETCH_PRED_TARGET,
    input  logic                     EX_VALID,
    input  logic                     EX_IS_BRANCH,
    input  logic                     EX_TAKEN,
    input  logic [31:0]              EX_TARGET,
    output logic                     STALL,
    output logic                     LEARN_VALID,
    output logic [31:0]              LEARN_PC,
    output logic [31:0]              LEARN_TARGET,
    output logic                     LEARN_SELECT,
    output logic                     REDIRECT_VALID,
    output logic [31:0]              REDIRECT_PC,
    output logic                     FLUSHING,
    output logic                     UNDERFLOW,
    output logic [CNT_W-1:0]         MISPREDICT_COUNT,
    output logic                     DBG_STATE,
    output logic [$clog2(DEPTH):0]   DBG_COUNT
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);
    localparam logic [OCC_W-1:0] FULL       = OCC_W'(DEPTH);
    localparam logic [FC_W-1:0]  FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // queue storage, no reset needed: an entry is only read while count > 0
    logic [31:0] q_pc     [DEPTH];
    logic        q_taken  [DEPTH];
    logic [31:0] q_target [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [OCC_W-1:0] count;
    state_t           state;
    logic [FC_W-1:0]  flush_cnt;

    logic        in_run;
    logic        pop;
    logic        push;
    logic        mispredict;
    logic [31:0] head_pc;
    logic        head_taken;
    logic [31:0] head_target;
    logic [31:0] correct_pc;

    always_comb begin
        in_run      = (state == RUN);
        head_pc     = q_pc[head];
        head_taken  = q_taken[head];
        head_target = q_target[head];
        pop         = EX_VALID && in_run && (count != '0);
        mispredict  = 1'b0;
        if (pop) begin
            if (EX_IS_BRANCH)
                mispredict = (EX_TAKEN != head_taken) ||
                             (EX_TAKEN && (EX_TARGET != head_target));
            else
                mispredict = head_taken;
        end
        // a mispredicting cycle discards fetch: it is already wrong-path
        push       = FETCH_VALID && in_run && !mispredict && ((count != FULL) || pop);
        correct_pc = (EX_IS_BRANCH && EX_TAKEN) ? EX_TARGET : head_pc + 32'd4;
    end

    assign STALL     = (count == FULL);
    assign FLUSHING  = (state == FLUSH);
    assign DBG_STATE = state;
    assign DBG_COUNT = count;

    always_ff @(posedge CLK) begin
        if (push) begin
            q_pc[tail]     <= FETCH_PC;
            q_taken[tail]  <= FETCH_PRED_TAKEN;
            q_target[tail] <= FETCH_PRED_TARGET;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            state            <= RUN;
            flush_cnt        <= '0;
            LEARN_VALID      <= 1'b0;
            LEARN_PC         <= '0;
            LEARN_TARGET     <= '0;
            LEARN_SELECT     <= 1'b0;
            REDIRECT_VALID   <= 1'b0;
            REDIRECT_PC      <= '0;
            UNDERFLOW        <= 1'b0;
            MISPREDICT_COUNT <= '0;
        end else begin
            // strobes last one cycle and their payload reads as zero when idle
            LEARN_VALID    <= 1'b0;
            LEARN_PC       <= '0;
            LEARN_TARGET   <= '0;
            LEARN_SELECT   <= 1'b0;
            REDIRECT_VALID <= 1'b0;
            REDIRECT_PC    <= '0;

            if (state == RUN) begin
                if (EX_VALID && (count == '0))
                    UNDERFLOW <= 1'b1;

                if (pop && (EX_IS_BRANCH || mispredict)) begin
                    LEARN_VALID  <= 1'b1;
                    LEARN_PC     <= head_pc;
                    LEARN_TARGET <= EX_TAKEN ? EX_TARGET : 32'd0;
                    LEARN_SELECT <= EX_IS_BRANCH && EX_TAKEN;
                end

                if (mispredict) begin
                    REDIRECT_VALID <= 1'b1;
                    REDIRECT_PC    <= correct_pc;
                    // every younger entry is wrong-path
                    head           <= '0;
                    tail           <= '0;
                    count          <= '0;
                    if (MISPREDICT_COUNT != '1)
                        MISPREDICT_COUNT <= MISPREDICT_COUNT + 1'b1;
                    state          <= FLUSH;
                    flush_cnt      <= FLUSH_LOAD;
                end else begin
                    if (push)
                        tail <= tail + 1'b1;
                    if (pop)
                        head <= head + 1'b1;
                    if (push && !pop)
                        count <= count + 1'b1;
                    else if (pop && !push)
                        count <= count - 1'b1;
                end
            end else begin
                // FLUSH: fetch and execute inputs are ignored entirely
                if (flush_cnt == '0)
                    state <= RUN;
                else
                    flush_cnt <= flush_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolution_unit.sv
module tb_branch_resolution_unit;

    localparam int DEPTH = 4;
    localparam int FC    = 2;
    localparam int CNT_W = 16;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic                 RST;
    logic                 FETCH_VALID;
    logic [31:0]          FETCH_PC;
    logic                 FETCH_PRED_TAKEN;
    logic [31:0]          FETCH_PRED_TARGET;
    logic                 EX_VALID;
    logic                 EX_IS_BRANCH;
    logic                 EX_TAKEN;
    logic [31:0]          EX_TARGET;
    logic                 STALL;
    logic                 LEARN_VALID;
    logic [31:0]          LEARN_PC;
    logic [31:0]          LEARN_TARGET;
    logic                 LEARN_SELECT;
    logic                 REDIRECT_VALID;
    logic [31:0]          REDIRECT_PC;
    logic                 FLUSHING;
    logic                 UNDERFLOW;
    logic [CNT_W-1:0]     MISPREDICT_COUNT;
    logic                 DBG_STATE;
    logic [$clog2(DEPTH):0] DBG_COUNT;

    branch_resolution_unit #(
        .DEPTH(DEPTH), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK), .RST(RST),
        .FETCH_VALID(FETCH_VALID), .FETCH_PC(FETCH_PC),
        .FETCH_PRED_TAKEN(FETCH_PRED_TAKEN), .FETCH_PRED_TARGET(FETCH_PRED_TARGET),
        .EX_VALID(EX_VALID), .EX_IS_BRANCH(EX_IS_BRANCH),
        .EX_TAKEN(EX_TAKEN), .EX_TARGET(EX_TARGET),
        .STALL(STALL),
        .LEARN_VALID(LEARN_VALID), .LEARN_PC(LEARN_PC),
        .LEARN_TARGET(LEARN_TARGET), .LEARN_SELECT(LEARN_SELECT),
        .REDIRECT_VALID(REDIRECT_VALID), .REDIRECT_PC(REDIRECT_PC),
        .FLUSHING(FLUSHING), .UNDERFLOW(UNDERFLOW),
        .MISPREDICT_COUNT(MISPREDICT_COUNT),
        .DBG_STATE(DBG_STATE), .DBG_COUNT(DBG_COUNT)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    int exp_mpc = 0;
    logic [98:0] exp_q[$];

    function automatic logic [98:0] rec(input logic lv, input logic [31:0] lpc,
                                        input logic [31:0] ltg, input logic lsel,
                                        input logic rv, input logic [31:0] rpc);
        return {lv, lpc, ltg, lsel, rv, rpc};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // advance one clock; any learn/redirect strobe is matched against exp_q
    task automatic tick();
        logic [98:0] act;
        logic [98:0] e;
        @(posedge CLK);
        #1;
        act = {LEARN_VALID, LEARN_PC, LEARN_TARGET, LEARN_SELECT, REDIRECT_VALID, REDIRECT_PC};
        if (LEARN_VALID || REDIRECT_VALID) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got %h expected no output", act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    n_err++;
                    $display("FAIL sb_record: got %h expected %h", act, e);
                end
            end
        end else begin
            chk("idle_payload_zero",
                LEARN_PC | LEARN_TARGET | REDIRECT_PC | {31'd0, LEARN_SELECT}, 32'd0);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clr();
        FETCH_VALID = 1'b0; FETCH_PC = '0; FETCH_PRED_TAKEN = 1'b0; FETCH_PRED_TARGET = '0;
        EX_VALID = 1'b0; EX_IS_BRANCH = 1'b0; EX_TAKEN = 1'b0; EX_TARGET = '0;
    endtask

    task automatic set_fetch(input logic [31:0] pc, input logic pt, input logic [31:0] ptg);
        FETCH_VALID = 1'b1; FETCH_PC = pc; FETCH_PRED_TAKEN = pt; FETCH_PRED_TARGET = ptg;
    endtask

    task automatic set_ex(input logic br, input logic tk, input logic [31:0] tgt);
        EX_VALID = 1'b1; EX_IS_BRANCH = br; EX_TAKEN = tk; EX_TARGET = tgt;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic pt, input logic [31:0] ptg);
        set_fetch(pc, pt, ptg);
        tick();
        clr();
    endtask

    task automatic resolve(input logic br, input logic tk, input logic [31:0] tgt);
        set_ex(br, tk, tgt);
        tick();
        clr();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] pc;  logic pt;  logic [31:0] ptg;
        logic br;         logic tk;  logic [31:0] tgt;
        logic lv;  logic [31:0] lpc; logic [31:0] ltg; logic lsel;
        logic rv;  logic [31:0] rpc;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            pc            pt    ptg           br    tk    tgt           lv    lpc           ltg           lsel  rv    rpc
        vecs[0] = '{32'h100,      1'b1, 32'h200,      1'b1, 1'b1, 32'h200,      1'b1, 32'h100,      32'h200,      1'b1, 1'b0, 32'h0};
        vecs[1] = '{32'h100,      1'b0, 32'h0,        1'b1, 1'b1, 32'h40,       1'b1, 32'h100,      32'h40,       1'b1, 1'b1, 32'h40};
        vecs[2] = '{32'h300,      1'b1, 32'h500,      1'b0, 1'b0, 32'h0,        1'b1, 32'h300,      32'h0,        1'b0, 1'b1, 32'h304};
        vecs[3] = '{32'h400,      1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
        vecs[4] = '{32'h500,      1'b1, 32'h600,      1'b1, 1'b1, 32'h700,      1'b1, 32'h500,      32'h700,      1'b1, 1'b1, 32'h700};
        vecs[5] = '{32'h600,      1'b1, 32'h800,      1'b1, 1'b0, 32'h999,      1'b1, 32'h600,      32'h0,        1'b0, 1'b1, 32'h604};
        vecs[6] = '{32'h700,      1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 32'h700,      32'h0,        1'b0, 1'b0, 32'h0};
        vecs[7] = '{32'hFFFFFFFC, 1'b1, 32'h10,       1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFFFFFC, 32'h0,        1'b0, 1'b1, 32'h0};
        vecs[8] = '{32'h800,      1'b0, 32'h0,        1'b0, 1'b1, 32'h123,      1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0};

        // ---------------- reset / idle ----------------
        clr();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        tick();
        chk("rst_stall", 32'(STALL), 32'd0);
        chk("rst_learn_valid", 32'(LEARN_VALID), 32'd0);
        chk("rst_redirect_valid", 32'(REDIRECT_VALID), 32'd0);
        chk("rst_flushing", 32'(FLUSHING), 32'd0);
        chk("rst_underflow", 32'(UNDERFLOW), 32'd0);
        chk("rst_mpc", 32'(MISPREDICT_COUNT), 32'd0);
        chk("rst_count", 32'(DBG_COUNT), 32'd0);
        chk("rst_state", 32'(DBG_STATE), 32'd0);

        // ---------------- single-entry vectors ----------------
        for (int i = 0; i < 9; i++) begin
            fetch(vecs[i].pc, vecs[i].pt, vecs[i].ptg);
            chk("vec_count_after_push", 32'(DBG_COUNT), 32'd1);
            if (vecs[i].lv || vecs[i].rv)
                exp_q.push_back(rec(vecs[i].lv, vecs[i].lpc, vecs[i].ltg,
                                    vecs[i].lsel, vecs[i].rv, vecs[i].rpc));
            resolve(vecs[i].br, vecs[i].tk, vecs[i].tgt);
            if (vecs[i].rv)
                exp_mpc++;
            chk("vec_learn_valid", 32'(LEARN_VALID), 32'(vecs[i].lv));
            chk("vec_redirect_valid", 32'(REDIRECT_VALID), 32'(vecs[i].rv));
            chk("vec_flushing", 32'(FLUSHING), 32'(vecs[i].rv));
            chk("vec_mpc", 32'(MISPREDICT_COUNT), 32'(exp_mpc));
            chk("vec_count_after_pop", 32'(DBG_COUNT), 32'd0);
            for (int k = 0; k < FC; k++)
                tick();
            chk("vec_back_to_run", 32'(FLUSHING), 32'd0);
        end

        // ---------------- direction mispredict with younger entries ----------------
        fetch(32'h100, 1'b0, 32'h0);
        fetch(32'h104, 1'b0, 32'h0);
        fetch(32'h108, 1'b0, 32'h0);
        chk("dm_count3", 32'(DBG_COUNT), 32'd3);
        exp_q.push_back(rec(1'b1, 32'h100, 32'h40, 1'b1, 1'b1, 32'h40));
        set_ex(1'b1, 1'b1, 32'h40);
        set_fetch(32'h10C, 1'b0, 32'h0);       // same-cycle fetch must be discarded
        tick();
        exp_mpc++;
        chk("dm_redirect_valid", 32'(REDIRECT_VALID), 32'd1);
        chk("dm_redirect_pc", REDIRECT_PC, 32'h40);
        chk("dm_count_cleared", 32'(DBG_COUNT), 32'd0);
        chk("dm_mpc", 32'(MISPREDICT_COUNT), 32'(exp_mpc));
        chk("dm_flushing_c0", 32'(FLUSHING), 32'd1);
        FETCH_VALID = 1'b0;
        set_ex(1'b1, 1'b0, 32'h0);             // EX_VALID held high through FLUSH
        tick();
        chk("dm_redirect_one_cycle", 32'(REDIRECT_VALID), 32'd0);
        chk("dm_flushing_c1", 32'(FLUSHING), 32'd1);
        tick();
        clr();
        chk("dm_flush_done", 32'(FLUSHING), 32'd0);
        chk("dm_no_underflow", 32'(UNDERFLOW), 32'd0);
        chk("dm_no_learn_in_flush", 32'(LEARN_VALID), 32'd0);

        // ---------------- full / wrap ----------------
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(rec(1'b1, 32'h1000 + 32'(4 * i), 32'h0, 1'b0, 1'b0, 32'h0));
            fetch(32'h1000 + 32'(4 * i), 1'b0, 32'h0);
        end
        chk("full_stall", 32'(STALL), 32'd1);
        chk("full_count", 32'(DBG_COUNT), 32'd4);
        fetch(32'h1010, 1'b0, 32'h0);          // dropped
        chk("full_drop_count", 32'(DBG_COUNT), 32'd4);
        exp_q.push_back(rec(1'b1, 32'h1014, 32'h0, 1'b0, 1'b0, 32'h0));
        set_fetch(32'h1014, 1'b0, 32'h0);
        set_ex(1'b1, 1'b0, 32'h0);
        tick();
        clr();
        chk("full_pushpop_count", 32'(DBG_COUNT), 32'd4);
        chk("full_pushpop_stall", 32'(STALL), 32'd1);
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(rec(1'b1, 32'h2000 + 32'(4 * i), 32'h0, 1'b0, 1'b0, 32'h0));
            set_fetch(32'h2000 + 32'(4 * i), 1'b0, 32'h0);
            set_ex(1'b1, 1'b0, 32'h0);
            tick();
            clr();
            chk("wrap_count", 32'(DBG_COUNT), 32'd4);
        end
        for (int i = 0; i < 4; i++)
            resolve(1'b1, 1'b0, 32'h0);
        chk("drain_count", 32'(DBG_COUNT), 32'd0);
        chk("drain_stall", 32'(STALL), 32'd0);
        chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);

        // ---------------- underflow ----------------
        chk("uf_before", 32'(UNDERFLOW), 32'd0);
        resolve(1'b1, 1'b1, 32'h50);
        chk("uf_set", 32'(UNDERFLOW), 32'd1);
        chk("uf_no_learn", 32'(LEARN_VALID), 32'd0);
        chk("uf_count", 32'(DBG_COUNT), 32'd0);
        tick();
        chk("uf_held", 32'(UNDERFLOW), 32'd1);

        // ---------------- reset mid-flush ----------------
        fetch(32'h900, 1'b1, 32'h950);
        exp_q.push_back(rec(1'b1, 32'h900, 32'h0, 1'b0, 1'b1, 32'h904));
        resolve(1'b0, 1'b0, 32'h0);
        chk("rmf_flushing", 32'(FLUSHING), 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        exp_mpc = 0;
        chk("rmf_state", 32'(DBG_STATE), 32'd0);
        chk("rmf_flushing_off", 32'(FLUSHING), 32'd0);
        chk("rmf_count", 32'(DBG_COUNT), 32'd0);
        chk("rmf_underflow", 32'(UNDERFLOW), 32'd0);
        chk("rmf_mpc", 32'(MISPREDICT_COUNT), 32'(exp_mpc));
        fetch(32'hA00, 1'b0, 32'h0);
        chk("rmf_push_after", 32'(DBG_COUNT), 32'd1);

        tick();
        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/branch_resolution_unit.md
Name: branch_resolution_unit

Overview:
Execute-side counterpart of the fetch-stage branch predictor. Records each prediction made at fetch in an in-order in-flight queue, compares it against the actual outcome when the instruction resolves in execute, and drives the predictor's learn interface. It also issues a fetch redirect and a flush on misprediction. It sits between the fetch-stage predictor outputs and the execute stage, and feeds the pipeline control logic.

Parameters:
DEPTH, 4, in-flight queue entries (power of two, 2..16)
FLUSH_CYCLES, 2, cycles spent in FLUSH after a redirect (>=1)
CNT_W, 16, width of the misprediction counter

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  synchronous, active-high reset
FETCH_VALID  in  1  an instruction was fetched this cycle with the prediction below
FETCH_PC  in  32  PC of the fetched instruction
FETCH_PRED_TAKEN  in  1  predictor status (1 = predicted taken)
FETCH_PRED_TARGET  in  32  predicted next PC when taken
EX_VALID  in  1  oldest in-flight instruction resolves this cycle
EX_IS_BRANCH  in  1  resolving instruction is a control transfer
EX_TAKEN  in  1  actual direction
EX_TARGET  in  32  actual target when taken
STALL  out  1  queue full; fetch must hold
LEARN_VALID  out  1  one-cycle learn strobe to the predictor
LEARN_PC  out  32  PC being trained (predictor PC_EXECUTION)
LEARN_TARGET  out  32  trained target (predictor PC_PREDICT_LEARN)
LEARN_SELECT  out  1  1 = install/keep taken entry, 0 = clear entry
REDIRECT_VALID  out  1  one-cycle strobe: fetch restarts at REDIRECT_PC
REDIRECT_PC  out  32  correct next PC
FLUSHING  out  1  high while in FLUSH state
UNDERFLOW  out  1  sticky: EX_VALID seen with empty queue
MISPREDICT_COUNT  out  CNT_W  saturating misprediction count

Behaviour:
- Reset (RST=1 at an edge): queue empty, FSM=RUN, all outputs 0. Reset dominates every other event, including one mid-flush.
- Queue: circular buffer with head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits. Each entry holds {pc, pred_taken, pred_target}.
- STALL = (count == DEPTH), combinational from registered count.
- Push occurs when FETCH_VALID & FSM==RUN & no mispredict this cycle, and either count<DEPTH or a pop occurs in the same cycle.
- A push while full without a pop is dropped. Fetch is required to honour STALL.
- Pop occurs when EX_VALID & FSM==RUN & count>0. Simultaneous push and pop leaves count unchanged.
- EX_VALID with count==0 sets UNDERFLOW, which holds until reset. No other effect.
- Resolution is combinational on the head entry during a pop:
  - Mispredict if EX_IS_BRANCH & (EX_TAKEN != pred_taken | (EX_TAKEN & EX_TARGET != pred_target)).
  - Mispredict also if !EX_IS_BRANCH & pred_taken.
  - correct_pc = (EX_IS_BRANCH & EX_TAKEN) ? EX_TARGET : head.pc + 32'd4. The add wraps modulo 2^32.
- Learn: registered, asserted the cycle after a pop when EX_IS_BRANCH, or when the instruction was mispredicted.
  - LEARN_PC = head.pc.
  - LEARN_TARGET = EX_TAKEN ? EX_TARGET : 0.
  - LEARN_SELECT = EX_IS_BRANCH & EX_TAKEN.
  - Learn outputs return to 0 when LEARN_VALID is low.
- Redirect: on a mispredicted pop, REDIRECT_VALID=1 and REDIRECT_PC=correct_pc are asserted the next cycle for exactly 1 cycle.
  - Also at that edge: the queue is cleared (younger entries are wrong-path), MISPREDICT_COUNT increments and saturates at all-ones, and the FSM moves RUN->FLUSH.
  - A same-cycle FETCH_VALID is discarded.
- FSM:
  - RUN: normal operation.
  - FLUSH: a down-counter is loaded with FLUSH_CYCLES-1. FLUSHING=1. FETCH_VALID and EX_VALID are ignored (no push, pop, learn or UNDERFLOW).
  - FLUSH->RUN when the counter reaches 0, so FLUSH lasts exactly FLUSH_CYCLES cycles.
- Latency: EX_VALID to LEARN/REDIRECT is 1 cycle. FETCH push is visible in count 1 cycle later.

Test Plan:
- Reset/idle: hold RST 2 cycles, then release -> all outputs 0, STALL=0, count 0.
- Correct prediction: push {pc=0x100, taken=1, target=0x200}; resolve branch taken to 0x200 -> LEARN_VALID=1, LEARN_PC=0x100, LEARN_TARGET=0x200, LEARN_SELECT=1; REDIRECT_VALID=0; count unchanged.
- Direction mispredict: push {0x100, taken=0}, then push 0x104 and 0x108; resolve branch taken to 0x40 -> next cycle REDIRECT_VALID=1, REDIRECT_PC=0x40, MISPREDICT_COUNT=1, queue empty, FLUSHING=1 for 2 cycles; EX_VALID during FLUSH is ignored (UNDERFLOW stays 0).
- False taken on non-branch: push {0x300, taken=1, target=0x500}; resolve EX_IS_BRANCH=0 -> REDIRECT_PC=0x304, LEARN_SELECT=0, LEARN_PC=0x300, LEARN_TARGET=0.
- Full/wrap: push 4 entries -> STALL=1; a 5th push alone is dropped; push and pop in the same cycle keeps count=4. Run 10 push/pop pairs -> pointers wrap and head PCs pop in FIFO order.
- Boundaries: EX_VALID with an empty queue -> UNDERFLOW=1, held. Non-branch at pc=0xFFFFFFFC mispredicted -> REDIRECT_PC=0x0. RST asserted mid-FLUSH -> FSM=RUN, count 0, UNDERFLOW=0.
